// File: rtl/q5_17_2s_deser_pkg.sv
// q5_17_2s_deser_pkg: shared types and constants for the serial-to-parallel
// collector that follows the serial two's-complement stage.
//   state_t             : collector FSM states
//   DESER_WIDTH_DEFAULT : default word width in bits
package q5_17_2s_deser_pkg;

  typedef enum logic {
    S_idle,
    S_collect
  } state_t;

  localparam int unsigned DESER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/q5_17_out_hold.sv
// q5_17_out_hold: one-deep valid/ready holding register for completed words.
// A completed word loads when the register is empty or is being read on the
// same edge; otherwise the word is dropped and the sticky overrun flag sets.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_load      : a completed word is offered this cycle
//   i_word      : the completed word
//   i_ready     : consumer accepts o_word when o_valid is high
//   o_word      : held word, stable while o_valid && !i_ready
//   o_valid     : o_word holds an unread word
//   o_overrun   : sticky, a completed word was dropped
module q5_17_out_hold
  import q5_17_2s_deser_pkg::*;
#(
  parameter int unsigned WIDTH = DESER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_overrun;
  logic             w_can_load;

  // Slot is free if empty, or if the held word leaves on this same edge.
  assign w_can_load = !r_valid || i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (i_load) begin
      if (w_can_load) begin
        r_word  <= i_word;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_word    = r_word;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/q5_17_2s_deser.sv
// q5_17_2s_deser: collects an LSB-first serial bit stream, framed by a start
// marker, into WIDTH-bit words presented on a valid/ready port.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   ser_in      : serial data bit, LSB first
//   ser_valid   : ser_in is valid this cycle
//   ser_start   : marks bit 0 of a word (only with ser_valid)
//   word_out    : assembled word, stable while word_valid is high and not read
//   word_valid  : word_out holds an unread word
//   word_ready  : consumer accepts on word_valid && word_ready
//   frame_err   : one-cycle pulse when a partial word is abandoned by a start
//   overrun     : sticky, a completed word was dropped
module q5_17_2s_deser
  import q5_17_2s_deser_pkg::*;
#(
  parameter int unsigned WIDTH = DESER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             ser_start,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned     CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_frame_err;

  logic             w_done;
  logic [WIDTH-1:0] w_word;

  // The final bit bypasses the shift register so the word is offered to the
  // holding register on the same edge that samples it.
  assign w_done = ser_valid && !ser_start && (r_state == S_collect) && (r_cnt == LAST);
  assign w_word = {ser_in, r_shift[WIDTH-2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_idle;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (ser_valid) begin
        case (r_state)
          S_idle: begin
            if (ser_start) begin
              r_shift[0] <= ser_in;
              r_cnt      <= CW'(1);
              r_state    <= S_collect;
            end
          end
          S_collect: begin
            if (ser_start) begin
              // A start always wins, even on what would be the last bit.
              r_frame_err <= 1'b1;
              r_shift[0]  <= ser_in;
              r_cnt       <= CW'(1);
            end else begin
              r_shift[r_cnt] <= ser_in;
              if (r_cnt == LAST) begin
                r_cnt   <= '0;
                r_state <= S_idle;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          default: r_state <= S_idle;
        endcase
      end
    end
  end

  assign frame_err = r_frame_err;

  q5_17_out_hold #(
    .WIDTH (WIDTH)
  ) u_out_hold (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_done),
    .i_word    (w_word),
    .i_ready   (word_ready),
    .o_word    (word_out),
    .o_valid   (word_valid),
    .o_overrun (overrun)
  );

endmodule
